// File: rtl/fir_sample_ctrl_if.sv
// fir_sample_ctrl_if
// Sample push handshake and coefficient write port of the FIR sample
// controller, bundled as one interface.
//   PushIn            : sample valid (master -> slave)
//   SampI / SampQ     : 1.23 signed sample, I and Q (master -> slave)
//   Busy              : slave cannot take a sample this cycle (slave -> master)
//   CoefWr            : coefficient write strobe (master -> slave)
//   CoefAddr          : coefficient bank address 0..14 (master -> slave)
//   CoefI / CoefQ     : coefficient value, I and Q (master -> slave)
//   CoefErr           : one-cycle pulse on a rejected write (slave -> master)
interface fir_sample_ctrl_if;
  logic        PushIn;
  logic [23:0] SampI;
  logic [23:0] SampQ;
  logic        Busy;
  logic        CoefWr;
  logic [3:0]  CoefAddr;
  logic [26:0] CoefI;
  logic [26:0] CoefQ;
  logic        CoefErr;

  modport master (
    output PushIn, SampI, SampQ, CoefWr, CoefAddr, CoefI, CoefQ,
    input  Busy, CoefErr
  );

  modport slave (
    input  PushIn, SampI, SampQ, CoefWr, CoefAddr, CoefI, CoefQ,
    output Busy, CoefErr
  );
endinterface

// File: rtl/fir_sample_ctrl.sv
// fir_sample_ctrl
// Control block of a 29-tap complex FIR: keeps the sample window and the
// coefficient bank, sequences the three-phase multiplier mux and schedules
// the accumulate / final-rounding strobes of the downstream datapath.
// Optional feature macro: FIR_SAMPLE_FLUSH_EN (adds the Flush input).
// Ports:
//   clk, reset_n                   : clock, asynchronous active-low reset
//   Flush                          : (FIR_SAMPLE_FLUSH_EN only) clear window in IDLE
//   bus                            : sample push + coefficient write interface
//   samp[29]                       : sample window {I,Q}, index 0 newest
//   coef[15]                       : coefficient bank {I,Q}
//   mux_sel                        : multiplier input select 0/1/2
//   partialProductAccumulate_valid : accumulate partial products
//   finalAccumulateRounding_en     : final accumulate + rounding strobe
//   WinFull                        : at least 29 samples accepted
module fir_sample_ctrl #(
  parameter int MULT_LAT = 2
) (
  input  logic               clk,
  input  logic               reset_n,
`ifdef FIR_SAMPLE_FLUSH_EN
  input  logic               Flush,
`endif
  fir_sample_ctrl_if.slave   bus,
  output logic [28:0][47:0]  samp,
  output logic [14:0][53:0]  coef,
  output logic [1:0]         mux_sel,
  output logic               partialProductAccumulate_valid,
  output logic               finalAccumulateRounding_en,
  output logic               WinFull
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEL0 = 2'd1;
  localparam logic [1:0] SEL1 = 2'd2;
  localparam logic [1:0] SEL2 = 2'd3;

  // Delay line bit k is set during cycle t=k after an acceptance.
  localparam int DL_W = MULT_LAT + 4;

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic                  busy_r;
  logic [1:0]            mux_sel_r;
  logic [DL_W-1:0]       dl_r;
  logic                  acc_valid_r;
  logic                  final_en_r;
  logic [28:0][47:0]     samp_r;
  logic [14:0][53:0]     coef_r;
  logic [4:0]            count_r;
  logic [4:0]            count_nxt_s;
  logic                  win_full_r;
  logic                  coef_err_r;
  logic                  flush_s;
  logic                  accept_s;
  logic                  coef_ok_s;
  logic                  coef_err_s;

  // Flush request, only honoured in IDLE.
  always_comb begin
`ifdef FIR_SAMPLE_FLUSH_EN
    flush_s = Flush & (state_r == IDLE);
`else
    flush_s = 1'b0;
`endif
  end

  // Acceptance, coefficient write qualification and occupancy update.
  always_comb begin
    accept_s    = bus.PushIn & ((state_r == IDLE) | (state_r == SEL2)) & ~flush_s;
    // A write is only safe with no final rounding still in flight.
    coef_ok_s   = bus.CoefWr & (state_r == IDLE) & ~(|dl_r) & (bus.CoefAddr <= 4'd14);
    coef_err_s  = bus.CoefWr & ~coef_ok_s;
    count_nxt_s = count_r;
    if (flush_s) begin
      count_nxt_s = 5'd0;
    end else if (accept_s && (count_r < 5'd29)) begin
      count_nxt_s = count_r + 5'd1;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Next-state logic of the mux sequencer.
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE:    state_nxt_s = accept_s ? SEL0 : IDLE;
      SEL0:    state_nxt_s = SEL1;
      SEL1:    state_nxt_s = SEL2;
      SEL2:    state_nxt_s = accept_s ? SEL0 : IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Sequencer state with Busy and mux_sel registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      busy_r    <= 1'b0;
      mux_sel_r <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == SEL0) | (state_nxt_s == SEL1);
      case (state_nxt_s)
        SEL0:    mux_sel_r <= 2'd0;
        SEL1:    mux_sel_r <= 2'd1;
        SEL2:    mux_sel_r <= 2'd2;
        default: mux_sel_r <= 2'd0;
      endcase
    end
  end

  // Delay line and the datapath strobes decoded from it; outputs are
  // registered, so each tap is taken one position early.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_r        <= {DL_W{1'b0}};
      acc_valid_r <= 1'b0;
      final_en_r  <= 1'b0;
    end else begin
      dl_r        <= {dl_r[DL_W-2:0], accept_s};
      acc_valid_r <= dl_r[MULT_LAT+1] | dl_r[MULT_LAT+2];
      final_en_r  <= dl_r[MULT_LAT+3];
    end
  end

  // Sample window shift and occupancy counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      samp_r     <= {29{48'd0}};
      count_r    <= 5'd0;
      win_full_r <= 1'b0;
    end else begin
      if (flush_s) begin
        samp_r <= {29{48'd0}};
      end else if (accept_s) begin
        samp_r <= {samp_r[27:0], bus.SampI, bus.SampQ};
      end
      count_r    <= count_nxt_s;
      win_full_r <= (count_nxt_s == 5'd29);
    end
  end

  // Coefficient bank writes and rejection pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coef_r     <= {15{54'd0}};
      coef_err_r <= 1'b0;
    end else begin
      if (coef_ok_s) begin
        coef_r[bus.CoefAddr] <= {bus.CoefI, bus.CoefQ};
      end
      coef_err_r <= coef_err_s;
    end
  end

  assign bus.Busy                       = busy_r;
  assign bus.CoefErr                    = coef_err_r;
  assign samp                           = samp_r;
  assign coef                           = coef_r;
  assign mux_sel                        = mux_sel_r;
  assign partialProductAccumulate_valid = acc_valid_r;
  assign finalAccumulateRounding_en     = final_en_r;
  assign WinFull                        = win_full_r;

endmodule
